// File: rtl/execute_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : execute_cycle
//  Purpose  : Execute stage of a 5-stage RV32I pipeline. Selects forwarded
//             operands, runs the ALU, resolves the branch/jump redirect and
//             registers the results into the E/M pipeline register.
//  Ports    :
//    clk, rst            clock / asynchronous active-low reset
//    RegWriteE..ALUSrcE  decoded control for the instruction in E
//    ALUControlE         ALU operation select
//    RD1_E, RD2_E        register-file read data
//    PCE, PCPlus4E       PC and PC+4 of the instruction in E
//    ImmExtE             sign-extended immediate
//    RD_E                destination register
//    ForwardA_E/B_E      forwarding selects from the hazard unit
//    ResultW             writeback result (forwarding source)
//    PCSrcE, PCTargetE   combinational redirect back to fetch
//    *M                  E/M pipeline register outputs
//  Revision : 1.0 - initial release
// ============================================================================
module execute_cycle #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic            ResultSrcE,
   input  logic            BranchE,
   input  logic            JumpE,
   input  logic            ALUSrcE,
   input  logic [2:0]      ALUControlE,
   input  logic [XLEN-1:0] RD1_E,
   input  logic [XLEN-1:0] RD2_E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [XLEN-1:0] ImmExtE,
   input  logic [4:0]      RD_E,
   input  logic [1:0]      ForwardA_E,
   input  logic [1:0]      ForwardB_E,
   input  logic [XLEN-1:0] ResultW,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic            ResultSrcM,
   output logic [4:0]      RD_M,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] ALU_ResultM
);

   localparam logic [2:0] c_ALU_ADD = 3'b000;
   localparam logic [2:0] c_ALU_SUB = 3'b001;
   localparam logic [2:0] c_ALU_AND = 3'b010;
   localparam logic [2:0] c_ALU_OR  = 3'b011;
   localparam logic [2:0] c_ALU_XOR = 3'b100;
   localparam logic [2:0] c_ALU_SLT = 3'b101;
   localparam logic [2:0] c_ALU_SLL = 3'b110;
   localparam logic [2:0] c_ALU_SRL = 3'b111;

   logic [XLEN-1:0] w_src_a;
   logic [XLEN-1:0] w_fwd_b;
   logic [XLEN-1:0] w_src_b;
   logic [XLEN-1:0] w_alu_result;
   logic            w_zero;
   logic [4:0]      w_shamt;

   // Forwarding: 10 takes this stage's own registered ALU result, so a
   // back-to-back dependent ALU op sees the value of the previous cycle.
   always_comb begin
      w_src_a = RD1_E;
      case (ForwardA_E)
         2'b01:   w_src_a = ResultW;
         2'b10:   w_src_a = ALU_ResultM;
         default: w_src_a = RD1_E;
      endcase
   end

   always_comb begin
      w_fwd_b = RD2_E;
      case (ForwardB_E)
         2'b01:   w_fwd_b = ResultW;
         2'b10:   w_fwd_b = ALU_ResultM;
         default: w_fwd_b = RD2_E;
      endcase
   end

   // The immediate replaces operand B for the ALU only; the forwarded value
   // still travels on as store data.
   assign w_src_b = ALUSrcE ? ImmExtE : w_fwd_b;
   assign w_shamt = w_src_b[4:0];

   always_comb begin
      w_alu_result = '0;
      case (ALUControlE)
         c_ALU_ADD: w_alu_result = w_src_a + w_src_b;
         c_ALU_SUB: w_alu_result = w_src_a - w_src_b;
         c_ALU_AND: w_alu_result = w_src_a & w_src_b;
         c_ALU_OR:  w_alu_result = w_src_a | w_src_b;
         c_ALU_XOR: w_alu_result = w_src_a ^ w_src_b;
         c_ALU_SLT: w_alu_result = {{(XLEN-1){1'b0}},
                                    ($signed(w_src_a) < $signed(w_src_b))};
         c_ALU_SLL: w_alu_result = w_src_a << w_shamt;
         c_ALU_SRL: w_alu_result = w_src_a >> w_shamt;
         default:   w_alu_result = '0;
      endcase
   end

   assign w_zero    = (w_alu_result == '0);
   // Only beq is decoded, so a branch is taken on a zero difference.
   assign PCSrcE    = (w_zero & BranchE) | JumpE;
   assign PCTargetE = PCE + ImmExtE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteM   <= 1'b0;
         MemWriteM   <= 1'b0;
         ResultSrcM  <= 1'b0;
         RD_M        <= '0;
         PCPlus4M    <= '0;
         WriteDataM  <= '0;
         ALU_ResultM <= '0;
      end else begin
         RegWriteM   <= RegWriteE;
         MemWriteM   <= MemWriteE;
         ResultSrcM  <= ResultSrcE;
         RD_M        <= RD_E;
         PCPlus4M    <= PCPlus4E;
         WriteDataM  <= w_fwd_b;
         ALU_ResultM <= w_alu_result;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_execute_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_cycle
//  Purpose  : Directed, table-driven bench for execute_cycle, plus
//             hand-written reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_execute_cycle;

   logic        clk;
   logic        rst;
   logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, PCE, PCPlus4E, ImmExtE, ResultW;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardA_E, ForwardB_E;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

   int n_tests = 0;
   int n_fail  = 0;

   execute_cycle #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .RegWriteE  (RegWriteE),
      .MemWriteE  (MemWriteE),
      .ResultSrcE (ResultSrcE),
      .BranchE    (BranchE),
      .JumpE      (JumpE),
      .ALUSrcE    (ALUSrcE),
      .ALUControlE(ALUControlE),
      .RD1_E      (RD1_E),
      .RD2_E      (RD2_E),
      .PCE        (PCE),
      .PCPlus4E   (PCPlus4E),
      .ImmExtE    (ImmExtE),
      .RD_E       (RD_E),
      .ForwardA_E (ForwardA_E),
      .ForwardB_E (ForwardB_E),
      .ResultW    (ResultW),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .RD_M       (RD_M),
      .PCPlus4M   (PCPlus4M),
      .WriteDataM (WriteDataM),
      .ALU_ResultM(ALU_ResultM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  aluc;
      logic        alusrc;
      logic [1:0]  fa, fb;
      logic [31:0] rd1, rd2, imm, resw;
      logic        branch, jump;
      logic [31:0] pc, pc4;
      logic [4:0]  rd;
      logic [2:0]  ctl;      // {RegWrite, MemWrite, ResultSrc}
      logic [31:0] e_alu, e_wd, e_target;
      logic        e_pcsrc;
   } vec_t;

   function automatic vec_t mk(
      input logic [2:0] aluc, input logic alusrc,
      input logic [1:0] fa, input logic [1:0] fb,
      input logic [31:0] rd1, input logic [31:0] rd2,
      input logic [31:0] imm, input logic [31:0] resw,
      input logic branch, input logic jump,
      input logic [31:0] pc, input logic [31:0] pc4,
      input logic [4:0] rd, input logic [2:0] ctl,
      input logic [31:0] e_alu, input logic [31:0] e_wd,
      input logic [31:0] e_target, input logic e_pcsrc);
      vec_t v;
      v.aluc = aluc; v.alusrc = alusrc; v.fa = fa; v.fb = fb;
      v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw;
      v.branch = branch; v.jump = jump; v.pc = pc; v.pc4 = pc4;
      v.rd = rd; v.ctl = ctl; v.e_alu = e_alu; v.e_wd = e_wd;
      v.e_target = e_target; v.e_pcsrc = e_pcsrc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      ALUControlE = v.aluc; ALUSrcE = v.alusrc;
      ForwardA_E  = v.fa;   ForwardB_E = v.fb;
      RD1_E = v.rd1; RD2_E = v.rd2; ImmExtE = v.imm; ResultW = v.resw;
      BranchE = v.branch; JumpE = v.jump; PCE = v.pc; PCPlus4E = v.pc4;
      RD_E = v.rd;
      {RegWriteE, MemWriteE, ResultSrcE} = v.ctl;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_regw"},  {31'd0, RegWriteM},  32'd0);
      chk({tag, "_memw"},  {31'd0, MemWriteM},  32'd0);
      chk({tag, "_rsrc"},  {31'd0, ResultSrcM}, 32'd0);
      chk({tag, "_rd"},    {27'd0, RD_M},       32'd0);
      chk({tag, "_pc4"},   PCPlus4M,            32'd0);
      chk({tag, "_wd"},    WriteDataM,          32'd0);
      chk({tag, "_alu"},   ALU_ResultM,         32'd0);
   endtask

   vec_t vecs[18];

   initial begin
      // Rows run in order; rows using forward-from-M depend on the row before.
      //          aluc    src fa     fb     rd1           rd2           imm           resw          br jp pc          pc4         rd     ctl     e_alu         e_wd          e_target      pcsrc
      vecs[0]  = mk(3'b000,1,2'b00,2'b00,32'd1,        32'd0,        32'd4,        32'd0,        0,0,32'h40,     32'h44,     5'd1,  3'b100, 32'd5,        32'd0,        32'h44,       0);
      vecs[1]  = mk(3'b000,1,2'b10,2'b00,32'd0,        32'd0,        32'd10,       32'd0,        0,0,32'h44,     32'h48,     5'd2,  3'b100, 32'd15,       32'd0,        32'h4E,       0);
      vecs[2]  = mk(3'b001,0,2'b01,2'b00,32'd0,        32'd1,        32'd0,        32'd100,      0,0,32'h48,     32'h4C,     5'd3,  3'b100, 32'd99,       32'd1,        32'h48,       0);
      vecs[3]  = mk(3'b101,0,2'b00,2'b00,32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        0,0,32'h50,     32'h54,     5'd4,  3'b100, 32'd1,        32'd1,        32'h50,       0);
      vecs[4]  = mk(3'b110,0,2'b00,2'b00,32'd1,        32'd33,       32'd0,        32'd0,        0,0,32'h54,     32'h58,     5'd5,  3'b100, 32'd2,        32'd33,       32'h54,       0);
      vecs[5]  = mk(3'b111,0,2'b00,2'b00,32'h80000000, 32'd31,       32'd0,        32'd0,        0,0,32'h58,     32'h5C,     5'd6,  3'b100, 32'd1,        32'd31,       32'h58,       0);
      vecs[6]  = mk(3'b100,0,2'b00,2'b00,32'h0000F0F0, 32'h00000FF0, 32'd0,        32'd0,        0,0,32'h5C,     32'h60,     5'd7,  3'b100, 32'h0000FF00, 32'h00000FF0, 32'h5C,       0);
      vecs[7]  = mk(3'b000,0,2'b00,2'b00,32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        0,0,32'h60,     32'h64,     5'd8,  3'b100, 32'd0,        32'd1,        32'h60,       0);
      vecs[8]  = mk(3'b010,0,2'b00,2'b00,32'h0000F0F0, 32'h00000FF0, 32'd0,        32'd0,        0,0,32'h64,     32'h68,     5'd9,  3'b100, 32'h000000F0, 32'h00000FF0, 32'h64,       0);
      vecs[9]  = mk(3'b011,0,2'b00,2'b00,32'h0000F0F0, 32'h00000FF0, 32'd0,        32'd0,        0,0,32'h68,     32'h6C,     5'd10, 3'b001, 32'h0000FFF0, 32'h00000FF0, 32'h68,       0);
      vecs[10] = mk(3'b001,0,2'b00,2'b00,32'd7,        32'd7,        32'hFFFFFFF8, 32'd0,        1,0,32'h100,    32'h104,    5'd0,  3'b000, 32'd0,        32'd7,        32'hF8,       1);
      vecs[11] = mk(3'b001,0,2'b00,2'b00,32'd7,        32'd8,        32'hFFFFFFF8, 32'd0,        1,0,32'h100,    32'h104,    5'd0,  3'b000, 32'hFFFFFFFF, 32'd8,        32'hF8,       0);
      vecs[12] = mk(3'b000,0,2'b00,2'b00,32'd3,        32'd4,        32'h00000010, 32'd0,        0,1,32'h20,     32'h24,     5'd1,  3'b100, 32'd7,        32'd4,        32'h30,       1);
      vecs[13] = mk(3'b000,1,2'b00,2'b01,32'h1000,     32'd5,        32'd8,        32'hDEAD,     0,0,32'h28,     32'h2C,     5'd0,  3'b010, 32'h1008,     32'hDEAD,     32'h30,       0);
      vecs[14] = mk(3'b000,1,2'b00,2'b10,32'd20,       32'd5,        32'd4,        32'd0,        0,0,32'h2C,     32'h30,     5'd0,  3'b010, 32'd24,       32'h1008,     32'h30,       0);
      vecs[15] = mk(3'b000,0,2'b11,2'b00,32'd5,        32'd3,        32'd0,        32'd99,       0,0,32'h30,     32'h34,     5'd11, 3'b100, 32'd8,        32'd3,        32'h30,       0);
      vecs[16] = mk(3'b001,0,2'b00,2'b10,32'd100,      32'd1,        32'd0,        32'd0,        0,0,32'h34,     32'h38,     5'd12, 3'b100, 32'd92,       32'd8,        32'h34,       0);
      vecs[17] = mk(3'b110,0,2'b00,2'b00,32'd3,        32'd32,       32'd0,        32'd0,        1,0,32'h38,     32'h3C,     5'd31, 3'b100, 32'd3,        32'd32,       32'h38,       0);

      // Reset held low with nonzero inputs: registers must stay clear.
      rst = 1'b0;
      apply(vecs[2]);
      repeat (3) @(posedge clk);
      #1 chk_all_zero("rst_hold");

      // Release reset with add 5+7 -> r3.
      @(negedge clk);
      rst = 1'b1;
      apply(mk(3'b000,0,2'b00,2'b00,32'd5,32'd7,32'd0,32'd0,0,0,32'h0,32'h4,
               5'd3,3'b100,32'd12,32'd7,32'h0,0));
      @(posedge clk);
      #1;
      chk("rst_rel_alu", ALU_ResultM, 32'd12);
      chk("rst_rel_rd",  {27'd0, RD_M}, 32'd3);

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         chk($sformatf("v%0d_pcsrc", i), {31'd0, PCSrcE}, {31'd0, vecs[i].e_pcsrc});
         chk($sformatf("v%0d_target", i), PCTargetE, vecs[i].e_target);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_alu", i), ALU_ResultM, vecs[i].e_alu);
         chk($sformatf("v%0d_wd", i), WriteDataM, vecs[i].e_wd);
         chk($sformatf("v%0d_rd", i), {27'd0, RD_M}, {27'd0, vecs[i].rd});
         chk($sformatf("v%0d_pc4", i), PCPlus4M, vecs[i].pc4);
         chk($sformatf("v%0d_ctl", i), {29'd0, RegWriteM, MemWriteM, ResultSrcM},
             {29'd0, vecs[i].ctl});
      end

      // Asynchronous reset between edges clears outputs before the next edge.
      @(negedge clk);
      apply(vecs[13]);
      @(posedge clk);
      #1 chk("async_pre_alu", ALU_ResultM, 32'h1008);
      #2 rst = 1'b0;
      #1 chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b1;
      apply(vecs[6]);
      @(posedge clk);
      #1;
      chk("async_post_alu", ALU_ResultM, 32'h0000FF00);
      chk("async_post_rd",  {27'd0, RD_M}, 32'd7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline. Sits between the decode-stage register outputs and the memory stage.
- Resolves forwarded operands, runs the ALU, and computes the branch/jump target and redirect.
- Registers the results into the E/M pipeline register that drives the memory stage.
- Redirect outputs (PCSrcE, PCTargetE) are combinational and go back to the fetch stage.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock; E/M register updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE  input  1 each  decoded control for the instruction in E.
- ALUControlE  input  3  ALU operation select.
- RD1_E, RD2_E  input  32  register-file read data.
- PCE, PCPlus4E, ImmExtE  input  32  PC, PC+4 and sign-extended immediate.
- RD_E  input  5  destination register.
- ForwardA_E, ForwardB_E  input  2  forwarding selects from the hazard unit.
- ResultW  input  32  writeback-stage result, used for forwarding.
- PCSrcE  output  1  taken-redirect to fetch (combinational).
- PCTargetE  output  32  branch/jump target, PCE + ImmExtE (combinational).
- RegWriteM, MemWriteM, ResultSrcM  output  1 each  registered control.
- RD_M  output  5  registered destination register.
- PCPlus4M, WriteDataM, ALU_ResultM  output  32  registered datapath values.

Behaviour:
Forwarding mux A (SrcA):
- ForwardA_E = 00: RD1_E.
- 01: ResultW.
- 10: ALU_ResultM (this block's own registered output).
- 11: RD1_E (reserved).

Forwarding mux B (fwdB):
- Same selection as mux A, applied to RD2_E with ForwardB_E.

SrcB:
- ALUSrcE = 1: ImmExtE. ALUSrcE = 0: fwdB.

ALU (ALUControlE):
- 000: add. 001: sub. 010: and. 011: or. 100: xor.
- 101: slt, signed compare, result 32'h1 or 0.
- 110: sll by SrcB[4:0]. 111: srl (logical) by SrcB[4:0].
- Add and sub wrap modulo 2^32; no overflow flag.
- ZeroE = (ALU result == 0).

Redirect:
- PCSrcE = (ZeroE & BranchE) | JumpE. Only beq is supported.
- PCTargetE = PCE + ImmExtE, wrap modulo 2^32.
- Both are purely combinational: valid in the same cycle the instruction is in E.

E/M register:
- On each rising clk, captures RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E, fwdB (-> WriteDataM) and the ALU result (-> ALU_ResultM).
- Latency is exactly 1 cycle. No stall or enable; the register updates every cycle.
- Bubbles arrive as zeroed control bits from the D/E register.

Reset:
- rst low clears all registered outputs to 0 immediately, independent of clk: RegWriteM, MemWriteM, ResultSrcM = 0; RD_M = 0; PCPlus4M, WriteDataM, ALU_ResultM = 0.
- Reset mid-operation discards the in-flight instruction.
- The first rising edge after rst deasserts captures the current E inputs.

Boundary conditions:
- Forward-from-M uses the registered ALU_ResultM, so back-to-back dependent ALU ops resolve correctly.
- ALUSrcE = 1 with ForwardB_E = 10: SrcB is the immediate, but WriteDataM still receives the forwarded value (store data).
- Shift amounts above 31 use only bits [4:0].
- JumpE = 1 forces PCSrcE = 1 regardless of ZeroE.
- BranchE = 1 with a nonzero difference gives PCSrcE = 0.

Test Plan:
1. Reset: hold rst low, drive nonzero inputs, toggle clk. All M outputs must stay 0. Release rst with add 5+7, RD_E = 3; after one edge: ALU_ResultM = 12, RD_M = 3.
2. Forwarding chain: cycle n add RD1 = 1, imm = 4 (ALUSrcE = 1) → ALU_ResultM = 5. Cycle n+1 ForwardA_E = 10, ImmExtE = 10 → ALU_ResultM = 15. Cycle n+2 ForwardA_E = 01, ResultW = 100, RD2 = 1, sub → ALU_ResultM = 99.
3. ALU ops: slt with −1 vs 1 → 1. sll 1 by 33 → 2. srl 0x80000000 by 31 → 1. xor 0xF0F0 ^ 0x0FF0 → 0xFF00. add 0xFFFFFFFF + 1 → 0.
4. Branch: BranchE = 1, sub, equal operands 7/7, PCE = 0x100, ImmExtE = 0xFFFFFFF8 → same cycle PCSrcE = 1, PCTargetE = 0xF8. With operands 7/8 → PCSrcE = 0.
5. Jump and store data: JumpE = 1, PCPlus4E = 0x24 → PCSrcE = 1 and PCPlus4M = 0x24 next cycle. Store with ALUSrcE = 1, ForwardB_E = 01, ResultW = 0xDEAD → WriteDataM = 0xDEAD, ALU_ResultM = base + imm.
6. Async reset mid-stream: assert rst between clock edges → outputs clear immediately, before the next edge.
